// File: rtl/pu_or1k_pkg.sv
// Shared types and constants for the cappuccino register file.
package pu_or1k_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_t;

    localparam int RF_R0 = 0;

endpackage

// File: rtl/pu_or1k_rf_ram_cappuccino.sv
// Register storage: one synchronous write port, two synchronous read ports, no bypass.
module pu_or1k_rf_ram_cappuccino #(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_RF_NUM        = 32
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] waddr,
    input  logic [OPTION_OPERAND_WIDTH-1:0] wdata,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] raddr_a,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] raddr_b,
    output logic [OPTION_OPERAND_WIDTH-1:0] rdata_a,
    output logic [OPTION_OPERAND_WIDTH-1:0] rdata_b
);

    logic [OPTION_OPERAND_WIDTH-1:0] mem [OPTION_RF_NUM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_a <= mem[raddr_a];
        rdata_b <= mem[raddr_b];
    end

endmodule

// File: rtl/pu_or1k_rf_cappuccino.sv
// Cappuccino GPR file: clear-on-reset walker, write bypass and stall coherence
// in front of a plain two-read one-write storage array.
module pu_or1k_rf_cappuccino
    import pu_or1k_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int OPTION_RF_ADDR_WIDTH = 5,
    parameter int OPTION_RF_NUM        = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            decode_valid_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfa_adr_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] rfb_adr_i,
    input  logic                            rf_wb_i,
    input  logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] result_i,
    output logic [OPTION_OPERAND_WIDTH-1:0] rfa_o,
    output logic [OPTION_OPERAND_WIDTH-1:0] rfb_o,
    output logic                            rf_ready_o
);

    localparam int AW = OPTION_RF_ADDR_WIDTH;
    localparam int DW = OPTION_OPERAND_WIDTH;
    localparam logic [AW-1:0] R0_ADR   = AW'(RF_R0);
    localparam logic [AW-1:0] LAST_ADR = AW'(OPTION_RF_NUM - 1);

    rf_state_t         state;
    rf_state_t         state_next;
    logic [AW-1:0]     clr_cnt;
    logic [AW-1:0]     clr_cnt_next;
    logic              run;

    logic [AW-1:0]     adr_a_p0;
    logic [AW-1:0]     adr_b_p0;
    logic [AW-1:0]     rd_adr_a;
    logic [AW-1:0]     rd_adr_b;
    logic              hit_a;
    logic              hit_b;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [DW-1:0]     ram_wdata;
    logic [DW-1:0]     ram_q_a;
    logic [DW-1:0]     ram_q_b;

    logic              zero_a_p1;
    logic              zero_b_p1;
    logic              byp_a_p1;
    logic              byp_b_p1;
    logic [DW-1:0]     byp_data_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_next;
            clr_cnt <= clr_cnt_next;
        end
    end

    // Counter freezes on the last entry; the transition to RUN happens on that clear.
    always_comb begin
        state_next   = state;
        clr_cnt_next = clr_cnt;
        if (state == CLEAR) begin
            if (clr_cnt == LAST_ADR) begin
                state_next = RUN;
            end else begin
                clr_cnt_next = clr_cnt + 1'b1;
            end
        end
    end

    assign run        = (state == RUN);
    assign rf_ready_o = run;

    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wb_rfd_adr_i;
        ram_wdata = result_i;
        if (!rst) begin
            if (!run) begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt;
                ram_wdata = '0;
            end else begin
                ram_we = rf_wb_i && (wb_rfd_adr_i != R0_ADR);
            end
        end
    end

    // Storage is re-read every cycle at the effective address, so a held operand
    // naturally picks up an earlier writeback one cycle after it lands.
    assign rd_adr_a = (run && decode_valid_i) ? rfa_adr_i : adr_a_p0;
    assign rd_adr_b = (run && decode_valid_i) ? rfb_adr_i : adr_b_p0;

    assign hit_a = run && rf_wb_i && (rd_adr_a != R0_ADR) && (wb_rfd_adr_i == rd_adr_a);
    assign hit_b = run && rf_wb_i && (rd_adr_b != R0_ADR) && (wb_rfd_adr_i == rd_adr_b);

    pu_or1k_rf_ram_cappuccino #(
        .OPTION_OPERAND_WIDTH(OPTION_OPERAND_WIDTH),
        .OPTION_RF_ADDR_WIDTH(OPTION_RF_ADDR_WIDTH),
        .OPTION_RF_NUM       (OPTION_RF_NUM)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr_a(rd_adr_a),
        .raddr_b(rd_adr_b),
        .rdata_a(ram_q_a),
        .rdata_b(ram_q_b)
    );

    // p0 -> p1: latch addresses and select flags for the output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            adr_a_p0  <= '0;
            adr_b_p0  <= '0;
            zero_a_p1 <= 1'b1;
            zero_b_p1 <= 1'b1;
            byp_a_p1  <= 1'b0;
            byp_b_p1  <= 1'b0;
        end else begin
            if (run && decode_valid_i) begin
                adr_a_p0 <= rfa_adr_i;
                adr_b_p0 <= rfb_adr_i;
            end
            zero_a_p1 <= !run || (rd_adr_a == R0_ADR);
            zero_b_p1 <= !run || (rd_adr_b == R0_ADR);
            byp_a_p1  <= hit_a;
            byp_b_p1  <= hit_b;
        end
    end

    always_ff @(posedge clk) begin
        byp_data_p1 <= result_i;
    end

    assign rfa_o = zero_a_p1 ? '0 : (byp_a_p1 ? byp_data_p1 : ram_q_a);
    assign rfb_o = zero_b_p1 ? '0 : (byp_b_p1 ? byp_data_p1 : ram_q_b);

endmodule

// File: tb/tb_pu_or1k_rf_cappuccino.sv
// Directed bench for the cappuccino register file with a behavioural reference model.
module tb_pu_or1k_rf_cappuccino;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int NUM = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          decode_valid_i;
    logic [AW-1:0] rfa_adr_i;
    logic [AW-1:0] rfb_adr_i;
    logic          rf_wb_i;
    logic [AW-1:0] wb_rfd_adr_i;
    logic [DW-1:0] result_i;
    logic [DW-1:0] rfa_o;
    logic [DW-1:0] rfb_o;
    logic          rf_ready_o;

    int n_cmp = 0;
    int n_bad = 0;

    pu_or1k_rf_cappuccino #(
        .OPTION_OPERAND_WIDTH(DW),
        .OPTION_RF_ADDR_WIDTH(AW),
        .OPTION_RF_NUM       (NUM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .decode_valid_i(decode_valid_i),
        .rfa_adr_i     (rfa_adr_i),
        .rfb_adr_i     (rfb_adr_i),
        .rf_wb_i       (rf_wb_i),
        .wb_rfd_adr_i  (wb_rfd_adr_i),
        .result_i      (result_i),
        .rfa_o         (rfa_o),
        .rfb_o         (rfb_o),
        .rf_ready_o    (rf_ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: register contents, ready flag, held operands and their addresses.
    logic [DW-1:0] mem_m [NUM];
    logic          m_run  = 1'b0;
    logic          m_live = 1'b0;
    int            m_cnt  = 0;
    logic [DW-1:0] m_a, m_b;
    logic [AW-1:0] m_la, m_lb;

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (rf_wb_i && wb_rfd_adr_i == a) return result_i;
        return mem_m[a];
    endfunction

    function automatic logic model_hit(input logic [AW-1:0] a);
        return rf_wb_i && a != 0 && wb_rfd_adr_i == a;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run  <= 1'b0;
            m_cnt  <= 0;
            m_a    <= '0;
            m_b    <= '0;
            m_la   <= '0;
            m_lb   <= '0;
            m_live <= 1'b1;
        end else if (!m_run) begin
            mem_m[m_cnt] <= '0;
            if (m_cnt == NUM - 1) m_run <= 1'b1;
            else m_cnt <= m_cnt + 1;
        end else begin
            if (decode_valid_i) begin
                m_la <= rfa_adr_i;
                m_lb <= rfb_adr_i;
                m_a  <= model_read(rfa_adr_i);
                m_b  <= model_read(rfb_adr_i);
            end else begin
                if (model_hit(m_la)) m_a <= result_i;
                if (model_hit(m_lb)) m_b <= result_i;
            end
            if (rf_wb_i && wb_rfd_adr_i != 0) mem_m[wb_rfd_adr_i] <= result_i;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            check("model_rfa", rfa_o, m_a);
            check("model_rfb", rfb_o, m_b);
            check("model_ready", {31'b0, rf_ready_o}, {31'b0, m_run});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_wb_i        = 1'b0;
        decode_valid_i = 1'b0;
    endtask

    task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        rf_wb_i      = 1'b1;
        wb_rfd_adr_i = a;
        result_i     = d;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        decode_valid_i = 1'b1;
        rfa_adr_i      = a;
        rfb_adr_i      = b;
    endtask

    // Reset pulse then the clear walk, with writeback and decode traffic that must be ignored.
    task automatic reset_and_clear();
        rst = 1'b1;
        idle();
        cyc();
        check("rst_ready", {31'b0, rf_ready_o}, '0);
        check("rst_rfa", rfa_o, '0);
        check("rst_rfb", rfb_o, '0);
        rst = 1'b0;
        write(5'd2, 32'h55);
        read(5'd7, 5'd2);
        for (int i = 1; i <= NUM; i++) begin
            cyc();
            if (i == NUM - 1) check("ready_edge31", {31'b0, rf_ready_o}, '0);
            if (i == NUM)     check("ready_edge32", {31'b0, rf_ready_o}, 32'd1);
            if (i < NUM)      check("clear_rfa", rfa_o, '0);
        end
        idle();
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rfa_adr_i    = '0;
        rfb_adr_i    = '0;
        wb_rfd_adr_i = '0;
        result_i     = '0;

        reset_and_clear();

        // Write issued during clear must not survive.
        read(5'd2, 5'd2);
        cyc();
        check("clear_wr_r2_a", rfa_o, '0);
        check("clear_wr_r2_b", rfb_o, '0);

        // Basic write then read.
        idle();
        write(5'd3, 32'h1234_5678);
        cyc();
        idle();
        read(5'd3, 5'd0);
        cyc();
        check("basic_rfa", rfa_o, 32'h1234_5678);
        check("basic_rfb_r0", rfb_o, '0);

        // Same-edge bypass to both ports.
        write(5'd5, 32'hA5A5_A5A5);
        read(5'd5, 5'd5);
        cyc();
        check("byp_rfa", rfa_o, 32'hA5A5_A5A5);
        check("byp_rfb", rfb_o, 32'hA5A5_A5A5);

        // Stall coherence: A holds r9, B holds r4.
        idle();
        write(5'd9, 32'h1);
        cyc();
        write(5'd4, 32'hCAFE_0004);
        cyc();
        idle();
        read(5'd9, 5'd4);
        cyc();
        check("stall_pre_a", rfa_o, 32'h1);
        check("stall_pre_b", rfb_o, 32'hCAFE_0004);
        idle();
        rfa_adr_i = 5'd3;
        rfb_adr_i = 5'd5;
        write(5'd9, 32'h2);
        cyc();
        check("stall_upd_a", rfa_o, 32'h2);
        check("stall_keep_b", rfb_o, 32'hCAFE_0004);
        idle();
        cyc();
        check("stall_hold_a", rfa_o, 32'h2);
        check("stall_hold_b", rfb_o, 32'hCAFE_0004);

        // r0 writes dropped, bypass suppressed.
        write(5'd0, 32'hFFFF_FFFF);
        read(5'd0, 5'd3);
        cyc();
        check("r0_byp", rfa_o, '0);
        check("r0_other", rfb_o, 32'h1234_5678);
        idle();
        read(5'd0, 5'd0);
        cyc();
        check("r0_read", rfa_o, '0);

        // Preload r7, then a mid-clear reset followed by a full reset walk.
        idle();
        write(5'd7, 32'hDEAD_BEEF);
        cyc();
        idle();
        read(5'd7, 5'd7);
        cyc();
        check("preload_r7", rfa_o, 32'hDEAD_BEEF);
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        reset_and_clear();
        read(5'd7, 5'd3);
        cyc();
        check("r7_cleared", rfa_o, '0);
        check("r3_cleared", rfb_o, '0);

        // Mixed traffic against the model, including a reset in the middle of RUN.
        for (int i = 0; i < 300; i++) begin
            rst            = (i == 150);
            decode_valid_i = ($urandom_range(0, 1) == 1);
            rf_wb_i        = ($urandom_range(0, 2) != 0);
            rfa_adr_i      = AW'($urandom_range(0, 7));
            rfb_adr_i      = AW'($urandom_range(0, 7));
            wb_rfd_adr_i   = AW'($urandom_range(0, 7));
            result_i       = $urandom;
            cyc();
        end
        rst = 1'b0;
        idle();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pu_or1k_rf_cappuccino.md
# pu_or1k_rf_cappuccino

General-purpose register file for the cappuccino pipeline. It accepts the writeback result stream produced by the writeback mux and serves two registered read ports to the decode/execute boundary. It forwards same-cycle writes to matching read addresses and keeps held operands coherent with later writebacks while decode is stalled. After reset it walks every entry to zero before reporting ready.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, register data width
- OPTION_RF_ADDR_WIDTH, 5, register address width
- OPTION_RF_NUM, 32, number of registers (= 2**OPTION_RF_ADDR_WIDTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- decode_valid_i  in  1  decode advances: sample new read addresses this cycle
- rfa_adr_i  in  OPTION_RF_ADDR_WIDTH  read port A address
- rfb_adr_i  in  OPTION_RF_ADDR_WIDTH  read port B address
- rf_wb_i  in  1  writeback enable
- wb_rfd_adr_i  in  OPTION_RF_ADDR_WIDTH  writeback destination
- result_i  in  OPTION_OPERAND_WIDTH  writeback data (writeback mux output)
- rfa_o  out  OPTION_OPERAND_WIDTH  operand A, registered
- rfb_o  out  OPTION_OPERAND_WIDTH  operand B, registered
- rf_ready_o  out  1  clear sequence done; file usable

## Operation
- FSM states CLEAR, RUN. rst forces CLEAR and sets clear counter to 0. In CLEAR, with rst low, each cycle writes 0 to entry[counter] and increments the counter. On the cycle that clears entry OPTION_RF_NUM-1, the FSM goes to RUN.
- While in CLEAR, rf_wb_i and decode_valid_i are ignored and rfa_o/rfb_o hold 0.
- Write in RUN: when rf_wb_i=1 and wb_rfd_adr_i!=0, entry[wb_rfd_adr_i] <= result_i. Writes to r0 are dropped.
- Reads of r0 always return 0.
- Read in RUN with decode_valid_i=1: each port latches its address and loads its output register from the entry.
  - Bypass: if the same cycle has a write to the same nonzero address, the output loads result_i instead of the stale entry.
- Hold in RUN with decode_valid_i=0: the outputs and latched addresses hold.
  - If rf_wb_i=1 and wb_rfd_adr_i equals a latched nonzero address, that port's output updates to result_i.
- Ports A and B are independent. Both may match the same write, and both then take result_i.

## Timing
- Reset values: rfa_o=0, rfb_o=0, rf_ready_o=0, latched addresses=0, state CLEAR, counter=0.
- rf_ready_o is registered (state==RUN). It rises exactly OPTION_RF_NUM rising edges after the first edge with rst low: the 32nd with default parameters.
- Read latency is 1 cycle: addresses presented with decode_valid_i at edge N appear on rfa_o/rfb_o after edge N.
- Write-to-read is 0-cycle via bypass. A write at edge N is visible to a read sampled at the same edge N.
- Stall update is 1 cycle: a matching write at edge N is reflected on the held output after edge N.
- rst asserted mid-CLEAR or mid-RUN restarts the clear from entry 0 on the next rst-low edge. Contents are then all zero when rf_ready_o rises.
- If the counter reaches OPTION_RF_NUM-1, it does not wrap; it is frozen in RUN.

## Structure
- Shared package pu_or1k_pkg carries:
  - the rf_state_t enum (CLEAR, RUN);
  - the constant RF_R0 = 0.
- One sub-module, pu_or1k_rf_ram_cappuccino: storage with 1 synchronous write port and 2 synchronous read ports, no internal bypass.
- The top block owns:
  - the FSM and counter;
  - the write-port mux (clear vs writeback);
  - r0 masking;
  - same-cycle bypass and stall-coherence compare;
  - the output registers.

## Test plan
- Reset clear: preload entry 7 with 0xDEADBEEF, pulse rst one cycle -> rf_ready_o=0 for 31 cycles, 1 on the 32nd; read r7 -> rfa_o=0.
- Basic: write r3=0x12345678, next cycle decode_valid_i with rfa_adr_i=3 -> rfa_o=0x12345678 one cycle later.
- Bypass: same edge write r5=0xA5A5A5A5 and read A=5, B=5 -> rfa_o=rfb_o=0xA5A5A5A5.
- Stall coherence: read A=9 (value 0x1) with decode_valid_i, then decode_valid_i=0 and write r9=0x2 -> rfa_o becomes 0x2 next cycle; rfb_o on address 4 unchanged.
- r0: write r0=0xFFFFFFFF, read A=0 -> rfa_o=0, including the same-cycle bypass case.
- Writes during CLEAR: rf_wb_i to r2=0x55 while rf_ready_o=0 -> after ready, r2 reads 0.
